compressor_pwm_driver: RTL

Converts the signed Q8.8 PID controller output into a slow-PWM compressor drive with anti-short-cycle protection. Sits directly downstream of the PID controller and generates the one-cycle sample strobe that drives the PID controller's `enable`. Together the two blocks form a fixed-rate control loop, one PID update per PWM period.

---
 rtl/compressor_pwm_driver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/compressor_pwm_driver.sv
// rtl/compressor_pwm_driver.sv - slow-PWM compressor drive with anti-short-cycle lockout
//
// Purpose: maps the signed Q8.8 PID output (negative = cooling demand) to a
// 256-tick PWM duty, holds the compressor off for a lockout interval after
// every enable, and emits the PID sample strobe once per PWM period.
//
// Ports:
//   clk        in   1        system clock
//   rst        in   1        synchronous active-high reset
//   enable     in   1        run request
//   pid_out    in   16 s     PID output, Q8.8
//   comp_on    out  1        compressor drive (registered)
//   pid_sample out  1        one-cycle strobe after each period end
//   duty_q     out  9        latched duty, 0..256 ticks
//   state      out  2        0 = IDLE, 1 = LOCKOUT, 2 = RUN
module compressor_pwm_driver #(
  parameter int PRESCALE        = 1000,
  parameter int LOCKOUT_PERIODS = 4,
  parameter int MIN_DUTY        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [15:0] pid_out,
  output logic               comp_on,
  output logic               pid_sample,
  output logic [8:0]         duty_q,
  output logic [1:0]         state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [7:0]    LOCK_LAST = 8'(LOCKOUT_PERIODS - 1);
  localparam logic [8:0]    DUTY_LO   = 9'(MIN_DUTY);
  localparam logic [8:0]    DUTY_HI   = 9'(256 - MIN_DUTY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKOUT = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t        st;
  logic [PW-1:0] presc;
  logic [7:0]    pwm_cnt;
  logic [7:0]    lock_cnt;

  logic          tick;
  logic          period_end;
  logic [14:0]   cool;
  logic [7:0]    raw;
  logic [8:0]    duty_next;

  assign state      = st;
  assign tick       = (st != IDLE) && (presc == PRE_LAST);
  assign period_end = tick && (pwm_cnt == 8'hFF);

  // Cooling magnitude; -32768 has no positive counterpart so it saturates.
  always_comb begin
    cool = 15'd0;
    if (pid_out[15]) begin
      if (pid_out == 16'sh8000) cool = 15'h7FFF;
      else                      cool = 15'(-pid_out);
    end
  end

  assign raw = 8'(cool >> 7);

  // Pulses shorter than MIN_DUTY ticks (on or off) are not worth a
  // compressor transition, so they snap to fully off / fully on.
  always_comb begin
    duty_next = {1'b0, raw};
    if ({1'b0, raw} < DUTY_LO)      duty_next = 9'd0;
    else if ({1'b0, raw} > DUTY_HI) duty_next = 9'd256;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      presc      <= '0;
      pwm_cnt    <= 8'd0;
      lock_cnt   <= 8'd0;
      duty_q     <= 9'd0;
      comp_on    <= 1'b0;
      pid_sample <= 1'b0;
    end else if ((st != IDLE) && !enable) begin
      // Dropping enable wins over a coincident period end: nothing latches.
      st         <= IDLE;
      presc      <= '0;
      pwm_cnt    <= 8'd0;
      lock_cnt   <= 8'd0;
      duty_q     <= 9'd0;
      comp_on    <= 1'b0;
      pid_sample <= 1'b0;
    end else begin
      comp_on    <= (st == RUN) && ({1'b0, pwm_cnt} < duty_q);
      pid_sample <= period_end;

      if (st == IDLE) begin
        presc    <= '0;
        pwm_cnt  <= 8'd0;
        lock_cnt <= 8'd0;
      end else if (tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      case (st)
        IDLE: begin
          if (enable) st <= LOCKOUT;
        end
        LOCKOUT: begin
          if (period_end) begin
            lock_cnt <= lock_cnt + 8'd1;
            if (lock_cnt == LOCK_LAST) begin
              st     <= RUN;
              duty_q <= duty_next;
            end
          end
        end
        RUN: begin
          if (period_end) duty_q <= duty_next;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
